// File: rtl/transpose_pingpong.sv
// rtl/transpose_pingpong.sv - double-buffered transpose buffer between the row and column DCT stages
//
// Purpose:
//   Two N_MAX x N_MAX banks of WIDTH-bit coefficients. One bank is filled with
//   TU rows while the other bank, which holds a completed TU, is unloaded one
//   column per cycle. TU size is chosen at runtime (4/8/16/32, clamped to N_MAX)
//   and latched per bank on row 0, so each bank drains with its own size.
//
// Optional build macro:
//   TRANSPOSE_MODE_EN - adds tr_mode/out_mode. tr_mode is latched per bank on
//   row 0. 1 = transpose (columns out), 0 = straight (rows replayed in order).
//   Without the macro the block always transposes.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   a row is present on din
//   in_ready   out  a row can be accepted (write bank not full)
//   tu_size    in   size code 0..3 = 4/8/16/32, sampled on row 0 of a TU
//   din        in   row lanes, lane c = din[c*WIDTH +: WIDTH]
//   tr_mode    in   (TRANSPOSE_MODE_EN only) 1 = transpose, 0 = straight
//   out_valid  out  a column is present on dout
//   out_ready  in   downstream accepts the column
//   dout       out  column lanes, lane r = element (row r, column ccnt)
//   out_size   out  latched size code of the bank being drained
//   out_mode   out  (TRANSPOSE_MODE_EN only) latched mode of the bank being drained
//   out_last   out  last column of the TU being drained

module transpose_pingpong #(
  parameter int WIDTH = 21,
  parameter int N_MAX = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             tu_size,
  input  logic [N_MAX*WIDTH-1:0] din,
`ifdef TRANSPOSE_MODE_EN
  input  logic                   tr_mode,
  output logic                   out_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_MAX*WIDTH-1:0] dout,
  output logic [1:0]             out_size,
  output logic                   out_last
);

  localparam int LG = $clog2(N_MAX);

  typedef logic [LG-1:0] idx_t;  // row / column index
  typedef logic [LG:0]   cnt_t;  // decoded size, can reach N_MAX

  // Storage: mem[bank][row][column]
  logic [WIDTH-1:0] mem [2][N_MAX][N_MAX];

  logic [1:0] full;           // one flag per bank
  logic [1:0] bank_size [2];  // latched size code per bank
`ifdef TRANSPOSE_MODE_EN
  logic [1:0] bank_mode;      // latched mode per bank
`endif

  logic wr_bank;
  logic rd_bank;
  idx_t rcnt;
  idx_t ccnt;

  cnt_t wr_size;
  cnt_t rd_size;
  logic wr_fire;
  logic rd_fire;
  logic wr_last;
  logic rd_last;
  logic rd_mode;

  // Size code to element count, clamped so oversize codes still fit the banks.
  function automatic cnt_t size_dec(input logic [1:0] code);
    int s;
    s = 4 << code;
    if (s > N_MAX) s = N_MAX;
    return cnt_t'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and counter terminal conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = !full[wr_bank];
    wr_fire  = in_valid & in_ready;
    // Row 0 decides the size of the TU, so it uses the live tu_size; later
    // rows use what was latched for the bank being written.
    if (rcnt == '0) wr_size = size_dec(tu_size);
    else            wr_size = size_dec(bank_size[wr_bank]);
    wr_last  = (cnt_t'(rcnt) == wr_size - cnt_t'(1));

    out_valid = full[rd_bank];
    rd_size   = size_dec(bank_size[rd_bank]);
    rd_last   = (cnt_t'(ccnt) == rd_size - cnt_t'(1));
    rd_fire   = out_valid & out_ready;
    out_last  = out_valid & rd_last;
    out_size  = bank_size[rd_bank];
`ifdef TRANSPOSE_MODE_EN
    rd_mode   = bank_mode[rd_bank];
    out_mode  = bank_mode[rd_bank];
`else
    rd_mode   = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Output lane mux. Lanes beyond the drained TU's size are forced to zero so
  // stale contents of unused rows/columns never leave the block.
  // ---------------------------------------------------------------------------
  always_comb begin
    dout = '0;
    if (out_valid) begin
      for (int r = 0; r < N_MAX; r++) begin
        if (r < int'(rd_size)) begin
          if (rd_mode) dout[r*WIDTH +: WIDTH] = mem[rd_bank][r][ccnt];
          else         dout[r*WIDTH +: WIDTH] = mem[rd_bank][ccnt][r];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      rcnt         <= '0;
      ccnt         <= '0;
      bank_size[0] <= 2'd0;
      bank_size[1] <= 2'd0;
`ifdef TRANSPOSE_MODE_EN
      bank_mode    <= '0;
`endif
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N_MAX; r++)
          for (int c = 0; c < N_MAX; c++)
            mem[b][r][c] <= '0;
    end else begin
      // Write side: only lanes inside the TU are stored.
      if (wr_fire) begin
        for (int c = 0; c < N_MAX; c++) begin
          if (c < int'(wr_size)) mem[wr_bank][rcnt][c] <= din[c*WIDTH +: WIDTH];
        end
        if (rcnt == '0) begin
          bank_size[wr_bank] <= tu_size;
`ifdef TRANSPOSE_MODE_EN
          bank_mode[wr_bank] <= tr_mode;
`endif
        end
        if (wr_last) begin
          wr_bank <= ~wr_bank;
          rcnt    <= '0;
        end else begin
          rcnt    <= rcnt + idx_t'(1);
        end
      end

      // Read side
      if (rd_fire) begin
        if (rd_last) begin
          rd_bank <= ~rd_bank;
          ccnt    <= '0;
        end else begin
          ccnt    <= ccnt + idx_t'(1);
        end
      end

      // A completing write targets a non-full bank and a completing read a
      // full one, so the two can never hit the same bank in one cycle.
      for (int b = 0; b < 2; b++) begin
        if (wr_fire && wr_last && (wr_bank == 1'(b)))
          full[b] <= 1'b1;
        else if (rd_fire && rd_last && (rd_bank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_transpose_pingpong.sv
// tb/tb_transpose_pingpong.sv - randomized self-checking bench for transpose_pingpong

module tb_transpose_pingpong;

  localparam int WIDTH = 21;
  localparam int N_MAX = 32;
  localparam int DW    = N_MAX * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    tu_size;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic [1:0]    out_size;
  logic          out_last;
`ifdef TRANSPOSE_MODE_EN
  logic          tr_mode;
  logic          out_mode;
`endif

  transpose_pingpong #(.WIDTH(WIDTH), .N_MAX(N_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tu_size   (tu_size),
    .din       (din),
`ifdef TRANSPOSE_MODE_EN
    .tr_mode   (tr_mode),
    .out_mode  (out_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_size  (out_size),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a matrix being collected, a queue of expected output
  // columns, and the number of complete TUs waiting to be drained.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mat [N_MAX][N_MAX];
  int               cur_rows = 0;
  int               cur_n    = 4;
  int               cur_code = 0;
  bit               cur_mode = 1'b1;
  logic [DW-1:0]    q_dout [$];
  logic [1:0]       q_size [$];
  bit               q_last [$];
  bit               q_mode [$];
  int               pending  = 0;
  int               rdy_mode = 1;   // 0 = out_ready low, 1 = high, 2 = random

  function automatic int sz(input int code);
    int n;
    n = 4 << code;
    return (n > N_MAX) ? N_MAX : n;
  endfunction

  task automatic model_row();
    logic [DW-1:0] v;
    if (cur_rows == 0) begin
      cur_code = int'(tu_size);
      cur_n    = sz(cur_code);
`ifdef TRANSPOSE_MODE_EN
      cur_mode = tr_mode;
`else
      cur_mode = 1'b1;
`endif
    end
    for (int c = 0; c < N_MAX; c++) mat[cur_rows][c] = din[c*WIDTH +: WIDTH];
    cur_rows++;
    if (cur_rows == cur_n) begin
      for (int k = 0; k < cur_n; k++) begin
        v = '0;
        for (int j = 0; j < cur_n; j++)
          v[j*WIDTH +: WIDTH] = cur_mode ? mat[j][k] : mat[k][j];
        q_dout.push_back(v);
        q_size.push_back(2'(cur_code));
        q_last.push_back(k == cur_n - 1);
        q_mode.push_back(cur_mode);
      end
      pending++;
      cur_rows = 0;
    end
  endtask

  // Cycle monitor: samples on the falling edge, before the handshake commits.
  initial begin
    bit can_in;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending  = 0;
        cur_rows = 0;
        q_dout.delete();
        q_size.delete();
        q_last.delete();
        q_mode.delete();
      end else begin
        can_in = (pending < 2);
        check("in_ready",  DW'(in_ready),  DW'(can_in));
        check("out_valid", DW'(out_valid), DW'(pending > 0));
        if (pending > 0) begin
          check("dout",     dout,            q_dout[0]);
          check("out_size", DW'(out_size),   DW'(q_size[0]));
          check("out_last", DW'(out_last),   DW'(q_last[0]));
`ifdef TRANSPOSE_MODE_EN
          check("out_mode", DW'(out_mode),   DW'(q_mode[0]));
`endif
          if (out_ready) begin
            if (q_last[0]) pending--;
            void'(q_dout.pop_front());
            void'(q_size.pop_front());
            void'(q_last.pop_front());
            void'(q_mode.pop_front());
          end
        end else begin
          check("dout_idle", dout,          '0);
          check("last_idle", DW'(out_last), '0);
        end
        if (in_valid && can_in) model_row();
      end
    end
  end

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all enter and leave 1 time unit after a rising edge.
  // dkind: 0 = 10*r+c, 1 = random, 2 = random with many -1 entries
  // ---------------------------------------------------------------------------
  task automatic send_rows(input int code, input int mode, input int nrows,
                           input int dkind, input int gap_pct);
    bit acc;
    int t;
    for (int r = 0; r < nrows; r++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      tu_size  = (r == 0) ? 2'(code) : 2'($urandom_range(3));
`ifdef TRANSPOSE_MODE_EN
      tr_mode  = (r == 0) ? 1'(mode) : 1'($urandom_range(1));
`else
      if (mode > 1) tu_size = 2'(code);
`endif
      for (int c = 0; c < N_MAX; c++) begin
        case (dkind)
          0:       din[c*WIDTH +: WIDTH] = WIDTH'(10 * r + c);
          1:       din[c*WIDTH +: WIDTH] = WIDTH'($urandom);
          default: din[c*WIDTH +: WIDTH] = ($urandom_range(1) == 1) ? {WIDTH{1'b1}} : WIDTH'($urandom);
        endcase
      end
      t = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 3000);
      if (!acc) begin
        check("accept_timeout", DW'(acc), DW'(1));
        return;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    rdy_mode = 1;
    t = 0;
    while (pending > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("drained", DW'(out_valid), DW'(0));
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    tu_size  = 2'd0;
    din      = '0;
`ifdef TRANSPOSE_MODE_EN
    tr_mode  = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  DW'(in_ready),  DW'(1));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_dout",      dout,           '0);
    check("rst_out_size",  DW'(out_size),  DW'(0));
    check("rst_out_last",  DW'(out_last),  DW'(0));
    @(posedge clk);
    #1;

    // 1: single 4x4, lane value 10*r+c
    rdy_mode = 1;
    send_rows(0, 1, 4, 0, 0);
    idle();
    wait_drain();

    // 2: back-to-back 32x32 with continuous valid/ready and negative values
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) send_rows(3, 1, 32, 2, 0);
    idle();
    wait_drain();

    // 3: two 8x8 TUs with downstream stalled, then release
    rdy_mode = 0;
    send_rows(1, 1, 8, 1, 0);
    send_rows(1, 1, 8, 1, 0);
    idle();
    repeat (4) @(posedge clk);
    #1;
    wait_drain();

    // 4: 16x16 then 4x4, tu_size scrambled on non-first rows
    rdy_mode = 2;
    send_rows(2, 1, 16, 1, 10);
    send_rows(0, 1, 4, 1, 10);
    idle();
    wait_drain();

    // 5: reset mid-TU while a previous TU is draining
    rdy_mode = 0;
    send_rows(0, 1, 4, 1, 0);
    rdy_mode = 2;
    send_rows(1, 1, 5, 1, 0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", DW'(out_valid), DW'(0));
    check("mid_rst_in_ready",  DW'(in_ready),  DW'(1));
    check("mid_rst_dout",      dout,           '0);
    check("mid_rst_out_size",  DW'(out_size),  DW'(0));
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send_rows(0, 1, 4, 1, 0);
    idle();
    wait_drain();

`ifdef TRANSPOSE_MODE_EN
    // 6: straight mode then transpose mode
    rdy_mode = 1;
    send_rows(0, 0, 4, 0, 0);
    send_rows(0, 1, 4, 0, 0);
    idle();
    wait_drain();
`endif

    // Randomized TUs: random sizes, modes, input gaps and output back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++)
      send_rows(int'($urandom_range(3)), int'($urandom_range(1)),
                sz(0) << 0 == 4 ? 0 : 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      int code;
      code = int'($urandom_range(3));
      send_rows(code, int'($urandom_range(1)), sz(code), 1, int'($urandom_range(30)));
    end
    idle();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_pingpong.md
Name: transpose_pingpong

Overview:
- Parametrised, double-buffered transpose buffer for the 2-D DCT pipeline, placed between the first (row) and second (column) 1-D transform stages.
- Accepts one TU row per cycle into one bank while emitting columns of the previously completed TU from the other bank, so load and unload overlap.
- Supports runtime TU sizes 4/8/16/32 up to N_MAX, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 21, bits per coefficient, signed.
- N_MAX, 32, maximum TU dimension and lane count; legal values are 4, 8, 16 and 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a row is present on din.
- in_ready  out  1  the block can accept a row.
- tu_size  in  2  0=4, 1=8, 2=16, 3=32; sampled on the first row of each TU.
- din  in  N_MAX*WIDTH  row lanes; lane c = din[c*WIDTH +: WIDTH].
- out_valid  out  1  a column is present on dout.
- out_ready  in  1  downstream accepts the column.
- dout  out  N_MAX*WIDTH  column lanes; lane r = element (row r, column ccnt).
- out_size  out  2  size code of the TU being drained.
- out_last  out  1  high on the last column of the TU.

Behaviour:
Storage and flags:
- Two banks, each N_MAX x N_MAX x WIDTH registers.
- Per-bank state: full flag, latched size code.
- Pointers: wr_bank, rd_bank (1 bit each); row counter rcnt and column counter ccnt (log2(N_MAX) bits each).

Size decode:
- S = 4 << code.
- Codes giving S > N_MAX clamp to N_MAX.

Write side:
- in_ready = !full[wr_bank].
- Accept = in_valid & in_ready. On accept, din lanes 0..S-1 are stored into row rcnt of wr_bank.
- If rcnt==0, tu_size is latched into that bank's size. tu_size on later rows of the same TU is ignored.
- On accept with rcnt==S-1: set full[wr_bank], toggle wr_bank, clear rcnt. Otherwise increment rcnt.

Read side:
- out_valid = full[rd_bank].
- dout lane r (r<S) = bank[rd_bank][r][ccnt]. Lanes r>=S drive 0. dout is 0 whenever out_valid is 0.
- out_size = latched size of rd_bank. out_last = out_valid & (ccnt==S-1).
- On out_valid & out_ready: if ccnt==S-1, clear full[rd_bank], toggle rd_bank and clear ccnt; otherwise increment ccnt.
- Holding out_ready low holds dout and ccnt stable.

Latency and throughput:
- First column of a TU is valid in the cycle after its last row is accepted.
- Sustained throughput is 1 row in + 1 column out per cycle, with no bubbles, when TUs are back to back and of equal size.

Boundary conditions:
- Both banks full: in_ready=0 until a drain completes. in_ready rises in the cycle after the out_last handshake.
- Both banks empty: out_valid=0.
- Write completion and read completion in the same cycle always target different banks; both take effect.
- A TU size change between TUs is legal. Each bank drains with its own latched size.
- Lanes >=S of din are ignored. Stale data in unused rows/columns of a bank is never output.

Reset:
- All storage, full flags, pointers and counters go to 0.
- Outputs at reset: in_ready=1, out_valid=0, dout=0, out_size=0, out_last=0.
- Reset mid-TU discards all partial and complete TUs.

Optional Feature:
- Macro: TRANSPOSE_MODE_EN.
- Defined:
  - Adds input port tr_mode (1 bit), latched per bank together with tu_size on row 0.
  - tr_mode=1: transpose, as described above.
  - tr_mode=0: straight mode. dout lane c = bank[rd_bank][ccnt][c], i.e. rows are replayed in arrival order. Handshake, latency and out_last timing are identical to transpose mode.
  - An out_mode output (1 bit) reports the latched mode of rd_bank.
- Undefined: neither port exists and the block always transposes.

Test Plan:
1. Reset, then 4 rows with tu_size=0, row r lane c = 10*r+c, out_ready=1 -> out_valid rises the cycle after row 3 is accepted; column c lanes 0..3 = c, 10+c, 20+c, 30+c; out_last on the 4th column; lanes 4..31 = 0.
2. Back-to-back 32x32 TUs, in_valid=1 and out_ready=1 continuously -> in_ready stays 1 throughout; 32 columns per TU with no gaps; values = transpose, including negative values (-1 sign-extended across WIDTH).
3. Fill two 8x8 TUs with out_ready=0 -> in_ready=0 after the 16th row; raising out_ready for 8 cycles -> in_ready returns 1 the cycle after out_last.
4. TU 16x16 followed by TU 4x4 (tu_size toggled only on row 0 of each, and changed mid-TU to check it is ignored) -> out_size=2 for 16 columns, then out_size=0 for 4 columns; data is correct for both.
5. Assert rst after 5 rows of an 8x8 TU while a previous TU is draining -> next cycle out_valid=0, in_ready=1, dout=0; a fresh 4x4 TU then transposes correctly.
6. With TRANSPOSE_MODE_EN defined, tr_mode=0 on a 4x4 TU -> dout replays rows 0..3 unchanged and out_mode=0; the next TU with tr_mode=1 is transposed.
